// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

   // Controller states: normal flow, dcache wait, halt drain, halted
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } pctrl_state_t;

   localparam int CNT_W_DEFAULT     = 32;
   localparam int DRAIN_ADV_DEFAULT = 3;

   // Bits needed to hold the values 0..max_val
   function automatic int ctr_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller and its environment.
interface pipeline_ctrl_if
   import pipeline_ctrl_pkg::*;
   #(parameter int CNT_W = CNT_W_DEFAULT);

   logic             ihit;
   logic             dhit;
   logic             mem_req;
   logic             hazard;
   logic             branch;
   logic             jump;
   logic             halt_id;
   logic             pc_en;
   logic             en_ifid;
   logic             flush_ifid;
   logic             en_idex;
   logic             flush_idex;
   logic             en_exmem;
   logic             en_memwb;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport ctrl (
      input  ihit, dhit, mem_req, hazard, branch, jump, halt_id,
      output pc_en, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem, en_memwb,
             halt, stall_cnt, flush_cnt
   );

   modport tb (
      output ihit, dhit, mem_req, hazard, branch, jump, halt_id,
      input  pc_en, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem, en_memwb,
             halt, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   output logic [CNT_W-1:0] value
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Count requested events, sticking at all-ones instead of wrapping
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         value <= CNT_ZERO;
      end else if (inc && (value != CNT_MAX)) begin
         value <= value + CNT_ONE;
      end else begin
         value <= value;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequences the 5-stage pipeline latches from hazard decisions and cache hits,
// drains the pipeline on HALT, and keeps stall/flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEFAULT,
   parameter int DRAIN_ADV = DRAIN_ADV_DEFAULT
) (
   input  logic         CLK,
   input  logic         nRST,
   pipeline_ctrl_if.ctrl pif
);

   localparam int             DCW        = ctr_width(DRAIN_ADV);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_ADV);
   localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

   pctrl_state_t   state_r, next_state_s;
   logic           ret_drain_r, ret_drain_next_s;
   logic [DCW-1:0] drain_ctr_r, drain_ctr_next_s;
   logic           run_s, drain_ctx_s, advance_s;
   logic           stall_inc_s, flush_inc_s;
   logic           pc_en_s, en_ifid_s, flush_ifid_s, en_idex_s, flush_idex_s;
   logic           en_exmem_s, en_memwb_s, halt_s;

   assign run_s       = (state_r == RUN);
   // A dcache wait entered from DRAIN still belongs to the drain sequence
   assign drain_ctx_s = (state_r == DRAIN) || ((state_r == MEM_WAIT) && ret_drain_r);

   // Latch controls and next state from the per-cycle priority rules
   always_comb begin
      next_state_s     = state_r;
      ret_drain_next_s = ret_drain_r;
      drain_ctr_next_s = drain_ctr_r;
      advance_s        = 1'b0;
      flush_inc_s      = 1'b0;
      pc_en_s          = 1'b0;
      en_ifid_s        = 1'b0;
      flush_ifid_s     = 1'b0;
      en_idex_s        = 1'b0;
      flush_idex_s     = 1'b0;
      en_exmem_s       = 1'b0;
      en_memwb_s       = 1'b0;
      halt_s           = 1'b0;
      if (!nRST) begin
         next_state_s = RUN;
      end else begin
         case (state_r)
            RUN, DRAIN: begin
               // In DRAIN the PC is held and IF/ID keeps loading bubbles
               if (pif.mem_req && !pif.dhit) begin
                  flush_ifid_s     = !run_s;
                  next_state_s     = MEM_WAIT;
                  ret_drain_next_s = !run_s;
               end else if (pif.mem_req && pif.dhit) begin
                  en_idex_s    = 1'b1;
                  en_exmem_s   = 1'b1;
                  en_memwb_s   = 1'b1;
                  flush_ifid_s = 1'b1;
                  advance_s    = 1'b1;
               end else if (!pif.ihit || (pif.hazard && run_s)) begin
                  en_exmem_s   = 1'b1;
                  en_memwb_s   = 1'b1;
                  flush_idex_s = 1'b1;
                  flush_ifid_s = !run_s;
                  advance_s    = 1'b1;
               end else if ((pif.branch || pif.jump) && run_s) begin
                  pc_en_s      = 1'b1;
                  en_ifid_s    = 1'b1;
                  en_idex_s    = 1'b1;
                  en_exmem_s   = 1'b1;
                  en_memwb_s   = 1'b1;
                  flush_ifid_s = 1'b1;
                  flush_inc_s  = 1'b1;
               end else if (pif.halt_id && run_s) begin
                  en_ifid_s        = 1'b1;
                  en_idex_s        = 1'b1;
                  en_exmem_s       = 1'b1;
                  en_memwb_s       = 1'b1;
                  flush_ifid_s     = 1'b1;
                  next_state_s     = DRAIN;
                  drain_ctr_next_s = DRAIN_ONE;
               end else begin
                  pc_en_s      = run_s;
                  en_ifid_s    = 1'b1;
                  en_idex_s    = 1'b1;
                  en_exmem_s   = 1'b1;
                  en_memwb_s   = 1'b1;
                  flush_ifid_s = !run_s;
                  advance_s    = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (pif.dhit) begin
                  en_idex_s    = 1'b1;
                  en_exmem_s   = 1'b1;
                  en_memwb_s   = 1'b1;
                  flush_ifid_s = 1'b1;
                  advance_s    = 1'b1;
                  next_state_s = ret_drain_r ? DRAIN : RUN;
               end else begin
                  next_state_s = MEM_WAIT;
               end
            end
            HALTED: begin
               halt_s = 1'b1;
            end
            default: begin
               next_state_s = RUN;
            end
         endcase
         // Count advancing drain cycles; the last one lands the halt in MEM/WB
         if (advance_s && drain_ctx_s && (drain_ctr_r == DRAIN_LAST)) begin
            next_state_s = HALTED;
         end else if (advance_s && drain_ctx_s) begin
            drain_ctr_next_s = drain_ctr_r + DRAIN_ONE;
         end else begin
            drain_ctr_next_s = drain_ctr_next_s;
         end
      end
   end

   // State, drain return flag and drain progress registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= RUN;
         ret_drain_r <= 1'b0;
         drain_ctr_r <= {DCW{1'b0}};
      end else begin
         state_r     <= next_state_s;
         ret_drain_r <= ret_drain_next_s;
         drain_ctr_r <= drain_ctr_next_s;
      end
   end

   assign stall_inc_s = nRST && !pc_en_s && (state_r != HALTED) && (state_r != DRAIN);

   assign pif.pc_en      = pc_en_s;
   assign pif.en_ifid    = en_ifid_s;
   assign pif.flush_ifid = flush_ifid_s;
   assign pif.en_idex    = en_idex_s;
   assign pif.flush_idex = flush_idex_s;
   assign pif.en_exmem   = en_exmem_s;
   assign pif.en_memwb   = en_memwb_s;
   assign pif.halt       = halt_s;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (stall_inc_s),
      .value (pif.stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (flush_inc_s),
      .value (pif.flush_cnt)
   );

endmodule
